// File: rtl/voq_burst_scheduler_pkg.sv
// ============================================================================
//  Module      : voq_burst_scheduler_pkg
//  Description : Shared types and helpers for the VOQ burst scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package voq_burst_scheduler_pkg;

    localparam int STAT_W = 16;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } sched_state_e;

    // Increment with wrap at n; n need not be a power of two.
    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/voq_burst_scheduler_rr_arbiter.sv
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational rotating find-first: the first request at or
//                after ptr, wrapping N-1 -> 0.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N     = 4,
    parameter int SEL_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             any_gnt
);

    int w_idx;

    // Scan from farthest to nearest so the request closest to ptr wins last.
    always_comb begin
        gnt_idx = '0;
        any_gnt = 1'b0;
        w_idx   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = int'(ptr) + k;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            if (req[w_idx]) begin
                gnt_idx = SEL_W'(w_idx);
                any_gnt = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/voq_burst_scheduler.sv
// ============================================================================
//  Module      : voq_burst_scheduler
//  Description : Round-robin VOQ pop scheduler with per-grant bursts of up to
//                BURST cells; optional per-channel statistics under the
//                VOQ_SCHED_STATS_EN macro.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module voq_burst_scheduler
    import voq_burst_scheduler_pkg::*;
#(
    parameter int PORT_NUB = 4,
    parameter int DEPTH    = 100,
    parameter int BURST    = 4,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int SEL_W    = (PORT_NUB > 1) ? $clog2(PORT_NUB) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PORT_NUB-1:0] empty,
    input  logic [ADDR_W-1:0]   rd_data,
    output logic                rd_en,
    output logic [SEL_W-1:0]    rd_sel,
    input  logic [PORT_NUB-1:0] port_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ADDR_W-1:0]   out_addr,
    output logic [SEL_W-1:0]    out_port,
    input  logic [SEL_W-1:0]    stat_sel,
    input  logic                stat_clr,
    output logic [STAT_W-1:0]   stat_cnt
);

    localparam int               c_cnt_w      = $clog2(BURST + 1);
    localparam logic [c_cnt_w-1:0] c_burst_last = c_cnt_w'(BURST);

    sched_state_e        r_state;
    logic [SEL_W-1:0]    r_rr_ptr;
    logic [SEL_W-1:0]    r_cur;
    logic [c_cnt_w-1:0]  r_burst_cnt;
    logic                r_out_valid;
    logic [ADDR_W-1:0]   r_out_addr;
    logic [SEL_W-1:0]    r_out_port;

    logic [PORT_NUB-1:0] w_req;
    logic                w_load_ok;
    logic [SEL_W-1:0]    w_gnt_idx;
    logic                w_any_gnt;
    logic                w_pop;
    logic [SEL_W-1:0]    w_pop_sel;

    assign w_req     = ~empty & port_ready;
    assign w_load_ok = ~r_out_valid | out_ready;

    rr_arbiter #(
        .N     (PORT_NUB),
        .SEL_W (SEL_W)
    ) u_rr_arbiter (
        .req     (w_req),
        .ptr     (r_rr_ptr),
        .gnt_idx (w_gnt_idx),
        .any_gnt (w_any_gnt)
    );

    always_comb begin
        w_pop     = 1'b0;
        w_pop_sel = w_gnt_idx;
        if (!rst && w_load_ok) begin
            if (r_state == ST_IDLE) begin
                w_pop = w_any_gnt;
            end else begin
                w_pop     = w_req[r_cur];
                w_pop_sel = r_cur;
            end
        end
    end

    assign rd_en     = w_pop;
    assign rd_sel    = w_pop_sel;
    assign out_valid = r_out_valid;
    assign out_addr  = r_out_addr;
    assign out_port  = r_out_port;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_cur       <= '0;
            r_burst_cnt <= '0;
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_out_port  <= '0;
        end else begin
            if (w_pop) begin
                r_out_valid <= 1'b1;
                r_out_addr  <= rd_data;
                r_out_port  <= w_pop_sel;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_cur       <= w_pop_sel;
                        r_burst_cnt <= c_cnt_w'(1);
                        if (BURST == 1) begin
                            r_rr_ptr <= SEL_W'(wrap_inc(int'(w_pop_sel), PORT_NUB));
                        end else begin
                            r_state <= ST_BURST;
                        end
                    end
                end
                ST_BURST: begin
                    // A dried-up or back-pressured port ends the burst early.
                    if (!w_req[r_cur]) begin
                        r_rr_ptr <= SEL_W'(wrap_inc(int'(r_cur), PORT_NUB));
                        r_state  <= ST_IDLE;
                    end else if (w_pop) begin
                        r_burst_cnt <= r_burst_cnt + 1'b1;
                        if ((r_burst_cnt + 1'b1) == c_burst_last) begin
                            r_rr_ptr <= SEL_W'(wrap_inc(int'(r_cur), PORT_NUB));
                            r_state  <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef VOQ_SCHED_STATS_EN
    logic [STAT_W-1:0] r_stat [PORT_NUB];

    always_ff @(posedge clk) begin
        for (int i = 0; i < PORT_NUB; i++) begin
            if (rst || stat_clr) begin
                r_stat[i] <= '0;
            end else if (w_pop && (w_pop_sel == SEL_W'(i)) && (r_stat[i] != '1)) begin
                r_stat[i] <= r_stat[i] + 1'b1;
            end
        end
    end

    always_comb begin
        stat_cnt = '0;
        for (int i = 0; i < PORT_NUB; i++) begin
            if (stat_sel == SEL_W'(i)) begin
                stat_cnt = r_stat[i];
            end
        end
    end
`else
    logic w_unused_stats;
    assign w_unused_stats = ^{stat_sel, stat_clr};
    assign stat_cnt       = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_voq_burst_scheduler.sv
// ============================================================================
//  Module      : tb_voq_burst_scheduler
//  Description : Randomised scoreboard bench for voq_burst_scheduler with a
//                behavioural VOQ and scheduling reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_voq_burst_scheduler;

    localparam int N      = 4;
    localparam int DEPTH  = 100;
    localparam int BURST  = 4;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int SEL_W  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      empty;
    logic [ADDR_W-1:0] rd_data;
    logic              rd_en;
    logic [SEL_W-1:0]  rd_sel;
    logic [N-1:0]      port_ready;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [SEL_W-1:0]  out_port;
    logic [SEL_W-1:0]  stat_sel;
    logic              stat_clr;
    logic [15:0]       stat_cnt;

    always #5 clk = ~clk;

    voq_burst_scheduler #(
        .PORT_NUB (N),
        .DEPTH    (DEPTH),
        .BURST    (BURST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .empty      (empty),
        .rd_data    (rd_data),
        .rd_en      (rd_en),
        .rd_sel     (rd_sel),
        .port_ready (port_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_port   (out_port),
        .stat_sel   (stat_sel),
        .stat_clr   (stat_clr),
        .stat_cnt   (stat_cnt)
    );

    typedef struct {
        int addr;
        int port;
    } cell_t;

    int                checks = 0;
    int                errors = 0;
    int                voq [N][$];
    logic [ADDR_W-1:0] head [N];
    cell_t             sb [$];

    // Reference scheduler: who holds the grant, how many cells taken, where RR resumes.
    int  m_ptr, m_cur, m_taken, m_pops [N];
    bit  m_holding, m_valid;

    assign rd_data = head[rd_sel];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            empty[i] = (voq[i].size() == 0);
            head[i]  = (voq[i].size() != 0) ? ADDR_W'(voq[i][0]) : '0;
        end
    endtask

    task automatic push(input int ch, input int cnt);
        for (int k = 0; k < cnt; k++) voq[ch].push_back(int'($urandom_range(0, DEPTH - 1)));
        refresh();
    endtask

    // mode 0: all ready; 1: random readiness; 2: downstream stalled; 3: caller-set
    task automatic cycle(input int mode);
        bit req [N];
        bit load_ok, pop;
        int ch;
        @(negedge clk);
        case (mode)
            0: begin port_ready = '1; out_ready = 1'b1; end
            1: begin port_ready = N'($urandom); out_ready = ($urandom_range(0, 3) != 0); end
            2: begin port_ready = '1; out_ready = 1'b0; end
            default: ;
        endcase
        #2;
        for (int i = 0; i < N; i++) req[i] = (voq[i].size() != 0) && port_ready[i];
        load_ok = !m_valid || out_ready;
        pop = 1'b0;
        ch  = 0;
        if (m_holding) begin
            if (!req[m_cur]) begin
                m_holding = 1'b0;
                m_ptr     = (m_cur + 1) % N;
            end else if (load_ok) begin
                pop = 1'b1;
                ch  = m_cur;
                m_taken++;
                if (m_taken == BURST) begin
                    m_holding = 1'b0;
                    m_ptr     = (m_cur + 1) % N;
                end
            end
        end else if (load_ok) begin
            for (int k = 0; k < N && !pop; k++) begin
                if (req[(m_ptr + k) % N]) begin
                    pop = 1'b1;
                    ch  = (m_ptr + k) % N;
                end
            end
            if (pop) begin
                m_cur   = ch;
                m_taken = 1;
                if (BURST == 1) m_ptr = (ch + 1) % N;
                else m_holding = 1'b1;
            end
        end
        check("rd_en", 32'(rd_en), 32'(pop));
        if (pop) begin
            check("rd_sel", 32'(rd_sel), 32'(ch));
            sb.push_back('{addr: voq[ch][0], port: ch});
        end
        @(posedge clk);
        #1;
        if (pop) begin
            void'(voq[ch].pop_front());
            m_pops[ch]++;
        end
        m_valid = pop ? 1'b1 : (out_ready ? 1'b0 : m_valid);
        refresh();
    endtask

    // Monitor: drains the scoreboard on every accepted output and checks hold stability.
    bit                hold_prev = 1'b0;
    logic [ADDR_W-1:0] prev_addr;
    logic [SEL_W-1:0]  prev_port;
    cell_t             got_exp;

    always @(negedge clk) begin
        #3;
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            check("out_valid", 32'(out_valid), 32'(m_valid));
            if (hold_prev) begin
                check("hold_addr", 32'(out_addr), 32'(prev_addr));
                check("hold_port", 32'(out_port), 32'(prev_port));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 32'(out_addr), 32'hFFFF_FFFF);
                end else begin
                    got_exp = sb.pop_front();
                    check("out_addr", 32'(out_addr), 32'(got_exp.addr));
                    check("out_port", 32'(out_port), 32'(got_exp.port));
                end
            end
            hold_prev = out_valid && !out_ready;
            prev_addr = out_addr;
            prev_port = out_port;
        end
    end

    initial begin
        rst        = 1'b1;
        port_ready = '1;
        out_ready  = 1'b1;
        stat_sel   = '0;
        stat_clr   = 1'b0;
        m_ptr = 0; m_cur = 0; m_taken = 0; m_holding = 1'b0; m_valid = 1'b0;
        for (int i = 0; i < N; i++) m_pops[i] = 0;
        refresh();
        push(0, 1);
        // rd_en must stay low under reset even with a non-empty channel.
        repeat (3) begin
            @(negedge clk);
            #2;
            check("rd_en_in_reset", 32'(rd_en), 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_addr", 32'(out_addr), 32'd0);
        check("rst_out_port", 32'(out_port), 32'd0);
        check("rst_stat_cnt", 32'(stat_cnt), 32'd0);

        repeat (4) cycle(0);
        push(2, 6);
        repeat (10) cycle(0);
        push(0, 1);
        push(1, 1);
        repeat (6) cycle(0);

        push(3, 3);
        cycle(0);
        repeat (5) cycle(2);
        repeat (6) cycle(0);

        push(1, 3);
        port_ready = 4'b1101;
        out_ready  = 1'b1;
        repeat (6) cycle(3);
        port_ready = 4'b1111;
        repeat (6) cycle(3);

        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 2) == 0) push(int'($urandom_range(0, N - 1)), int'($urandom_range(1, 3)));
            cycle(1);
        end

        for (int c = 0; c < 400; c++) cycle(0);
        check("sb_drained", 32'(sb.size()), 32'd0);
        for (int i = 0; i < N; i++) check("voq_drained", 32'(voq[i].size()), 32'd0);

        for (int i = 0; i < N; i++) begin
            stat_sel = SEL_W'(i);
            cycle(0);
`ifdef VOQ_SCHED_STATS_EN
            check("stat_cnt", 32'(stat_cnt), 32'(m_pops[i]));
`else
            check("stat_cnt", 32'(stat_cnt), 32'd0);
`endif
        end
        stat_clr = 1'b1;
        cycle(0);
        stat_clr = 1'b0;
        for (int i = 0; i < N; i++) begin
            stat_sel = SEL_W'(i);
            cycle(0);
            check("stat_clr", 32'(stat_cnt), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
